// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared immediate-type encodings, error codes and per-type immediate masks
// No ports; imported by imm_pack and imm_encoder.
package imm_encoder_pkg;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;
  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  // Illegal types own no immediate bits, so the base instruction passes through untouched.
  function automatic logic [31:0] imm_mask(input logic [2:0] immsrc);
    return immsrc == IMM_I ? MASK_I :
           immsrc == IMM_S ? MASK_S :
           immsrc == IMM_B ? MASK_B :
           immsrc == IMM_J ? MASK_J :
           immsrc == IMM_U ? MASK_U : 32'h0;
  endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational packing of an immediate into a base instruction plus range/alignment check
// Ports: i_immsrc (type), i_imm (value), i_base_instr (non-immediate fields) -> o_instr, o_err.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  i_immsrc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_base_instr,
  output logic [31:0] o_instr,
  output logic [1:0]  o_err
);
  logic [31:0] w_field;
  logic [31:0] w_mask;
  logic        w_illegal;
  logic        w_align;
  logic        w_range;
  assign w_field = i_immsrc == IMM_I ? {i_imm[11:0], 20'h0} :
                   i_immsrc == IMM_S ? {i_imm[11:5], 13'h0, i_imm[4:0], 7'h0} :
                   i_immsrc == IMM_B ? {i_imm[12], i_imm[10:5], 13'h0, i_imm[4:1], i_imm[11], 7'h0} :
                   i_immsrc == IMM_J ? {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h0} :
                   i_immsrc == IMM_U ? {i_imm[31:12], 12'h0} : 32'h0;
  assign w_mask    = imm_mask(i_immsrc);
  assign w_illegal = i_immsrc > IMM_U;
  assign w_align   = (i_immsrc == IMM_B || i_immsrc == IMM_J) && i_imm[0];
  // Sign-extension check: every bit above the encodable field must match its top bit.
  assign w_range   = (i_immsrc == IMM_I || i_immsrc == IMM_S) ? !(&i_imm[31:11] || ~|i_imm[31:11]) :
                     i_immsrc == IMM_B ? !(&i_imm[31:12] || ~|i_imm[31:12]) :
                     i_immsrc == IMM_J ? !(&i_imm[31:20] || ~|i_imm[31:20]) :
                     i_immsrc == IMM_U ? |i_imm[11:0] : 1'b0;
  assign o_err     = w_illegal ? ERR_ILLEGAL : w_align ? ERR_ALIGN : w_range ? ERR_RANGE : ERR_OK;
  // Errored results keep the base fields but zero the immediate positions.
  assign o_instr   = (i_base_instr & ~w_mask) | (o_err == ERR_OK ? w_field : 32'h0);
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline around imm_pack with a saturating error counter
// Ports: clk, reset (async, active-high); in_valid/in_ready with immsrc, imm, base_instr;
//        out_valid/out_ready with out_instr, out_err; err_count counts errored output transfers.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_count
);
  logic        r_s1_valid;
  logic [31:0] r_s1_instr;
  logic [1:0]  r_s1_err;
  logic [31:0] w_instr;
  logic [1:0]  w_err;
  logic        w_s2_load;
  logic        w_s1_adv;
  imm_pack u_pack (
    .i_immsrc    (immsrc),
    .i_imm       (imm),
    .i_base_instr(base_instr),
    .o_instr     (w_instr),
    .o_err       (w_err)
  );
  assign w_s2_load = !out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= 32'h0;
      r_s1_err   <= ERR_OK;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_err    <= ERR_OK;
      err_count  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        r_s1_instr <= w_instr;
        r_s1_err   <= w_err;
      end
      if (w_s2_load) out_valid <= r_s1_valid;
      if (w_s1_adv) begin
        out_instr <= r_s1_instr;
        out_err   <= r_s1_err;
      end
      if (out_valid && out_ready && out_err != ERR_OK && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against a bit-table reference model
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  immsrc = 3'd0;
  logic [31:0] imm = 32'h0;
  logic [31:0] base_instr = 32'h0;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_instr, out_instr2;
  logic [1:0]  out_err, out_err2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  bit          rnd_rdy = 1'b0;

  typedef struct packed {logic [31:0] instr; logic [1:0] err;} res_t;
  typedef struct packed {res_t r; logic [2:0] t; logic [31:0] v;} exp_t;
  res_t got_q[$];
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int n_err = 0;

  imm_encoder #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );
  imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .immsrc(immsrc), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_err(out_err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && out_valid && out_ready) got_q.push_back({out_instr, out_err});

  // Where each immediate bit lands in the instruction, straight from the format tables.
  function automatic logic [31:0] m_place(input logic [2:0] t, input logic [31:0] v);
    logic [31:0] x;
    x = 32'h0;
    for (int k = 0; k < 32; k++) begin
      int p;
      p = -1;
      case (t)
        3'd0: if (k < 12) p = 20 + k;
        3'd1: if (k < 5) p = 7 + k; else if (k < 12) p = 20 + k;
        3'd2: if (k >= 1 && k <= 4) p = 7 + k; else if (k >= 5 && k <= 10) p = 20 + k;
              else if (k == 11) p = 7; else if (k == 12) p = 31;
        3'd3: if (k >= 1 && k <= 10) p = 20 + k; else if (k == 11) p = 20;
              else if (k >= 12 && k <= 19) p = k; else if (k == 20) p = 31;
        3'd4: if (k >= 12) p = k;
        default: ;
      endcase
      if (p >= 0) x[p] = v[k];
    end
    return x;
  endfunction

  function automatic logic [1:0] m_err(input logic [2:0] t, input logic [31:0] v);
    int s;
    s = $signed(v);
    if (t > 3'd4) return 2'd3;
    if ((t == 3'd2 || t == 3'd3) && v[0]) return 2'd2;
    case (t)
      3'd0, 3'd1: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
      3'd2: return (s < -4096 || s > 4095) ? 2'd1 : 2'd0;
      3'd3: return (s < -1048576 || s > 1048575) ? 2'd1 : 2'd0;
      default: return (v % 4096 != 0) ? 2'd1 : 2'd0;
    endcase
  endfunction

  function automatic res_t m_exp(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
    res_t r;
    logic [31:0] mask;
    mask = m_place(t, 32'hFFFF_FFFF);
    r.err = m_err(t, v);
    r.instr = r.err == 2'd3 ? b : r.err != 2'd0 ? (b & ~mask) : ((b & ~mask) | m_place(t, v));
    return r;
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] x, input logic [2:0] t);
    case (t)
      3'd0: return {{20{x[31]}}, x[31:20]};
      3'd1: return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd2: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd3: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return {x[31:12], 12'h0};
    endcase
  endfunction

  task automatic rand_req(input bit legal_only, output logic [2:0] t, output logic [31:0] v, output logic [31:0] b);
    logic [31:0] r;
    logic signed [31:0] s;
    int w;
    r = $urandom;
    t = 3'($urandom_range(0, 4));
    w = t <= 3'd1 ? 12 : t == 3'd2 ? 13 : 21;
    s = r << (32 - w);
    v = s >>> (32 - w);
    if (t == 3'd2 || t == 3'd3) v[0] = 1'b0;
    if (t == 3'd4) v = r & 32'hFFFF_F000;
    if (!legal_only && $urandom_range(0, 3) == 0) v = $urandom;
    if (!legal_only && $urandom_range(0, 7) == 0) t = 3'($urandom_range(5, 7));
    b = $urandom;
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b, output int cyc);
    logic acc;
    exp_t e;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b1; immsrc = t; imm = v; base_instr = b;
    while (!acc && cyc < 100) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_accept: in_ready stayed %0b, required 1 within 100 cycles", in_ready);
    end else begin
      e.r = m_exp(t, v, b); e.t = t; e.v = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_out();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL out_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({out_valid, out_instr, out_err, err_count, err_count2} !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b i=%h e=%0d c=%0d, required all zero", out_valid, out_instr, out_err, err_count);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_i_type();
    int c;
    res_t g;
    exp_t e;
    out_ready = 1'b1;
    send(3'd0, 32'hFFFF_F800, 32'h0000_0013, c);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL i_latency_early: out_valid=%0b, required 0", out_valid); end
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_instr, out_err} !== {1'b1, 32'h8000_0013, 2'd0}) begin
      bad++;
      $display("FAIL i_type: got v=%0b %h/%0d, required 1 80000013/0", out_valid, out_instr, out_err);
    end
    wait_out();
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL i_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
  endtask

  task automatic test_b_type();
    int c;
    res_t g;
    exp_t e;
    send(3'd2, 32'hFFFF_FFFE, 32'h0000_0063, c);
    send(3'd2, 32'h0000_0003, 32'h0000_0063, c);
    wait_out();
    total++;
    if (got_q.size() != 2 || got_q[0] !== {32'hFE00_0FE3, 2'd0} || got_q[1] !== {32'h0000_0063, 2'd2}) begin
      bad++;
      $display("FAIL b_directed: got %0d results first %h/%0d, required FE000FE3/0 then 00000063/2",
               got_q.size(), got_q.size() ? got_q[0].instr : 32'h0, got_q.size() ? got_q[0].err : 2'd0);
    end
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL b_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
    total++;
    if (err_count !== 8'd1) begin bad++; $display("FAIL b_err_count: got %0d, required 1", err_count); end
  endtask

  task automatic test_range_illegal();
    int c;
    res_t g;
    exp_t e;
    send(3'd3, 32'h0010_0000, 32'h0000_006F, c);
    send(3'd4, 32'h0000_1001, 32'h0000_0037, c);
    send(3'd6, 32'h1234_5678, 32'hABCD_EF01, c);
    wait_out();
    total++;
    if (got_q.size() != 3 || got_q[0].err !== 2'd1 || got_q[1].err !== 2'd1 || got_q[2] !== {32'hABCD_EF01, 2'd3}) begin
      bad++;
      $display("FAIL range_illegal_directed: got %0d results, required errs 1,1,3 and last instr ABCDEF01", got_q.size());
    end
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL ri_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
    total++;
    if (err_count !== 8'd4 || err_count2 !== 2'd3) begin
      bad++;
      $display("FAIL ri_err_count: got %0d/%0d, required 4/3", err_count, err_count2);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] t[4];
    logic [31:0] v[4], b[4];
    logic [31:0] hold;
    int acc;
    res_t g;
    exp_t e;
    for (int i = 0; i < 4; i++) rand_req(1'b1, t[i], v[i], b[i]);
    out_ready = 1'b0;
    acc = 0;
    hold = 32'h0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; immsrc = t[acc]; imm = v[acc]; base_instr = b[acc];
      @(negedge clk);
      if (c == 3) hold = out_instr;
      if (in_ready) begin e.r = m_exp(t[acc], v[acc], b[acc]); e.t = t[acc]; e.v = v[acc]; exp_q.push_back(e); acc++; end
      @(posedge clk); #1;
    end
    total++;
    if (acc != 2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: accepted %0d in_ready=%0b, required 2 and 0", acc, in_ready); end
    total++;
    if (out_valid !== 1'b1 || out_instr !== hold || got_q.size() != 0) begin
      bad++;
      $display("FAIL bp_hold: got v=%0b %h, required 1 %h", out_valid, out_instr, hold);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      in_valid = 1'b1; immsrc = t[acc]; imm = v[acc]; base_instr = b[acc];
      @(negedge clk);
      if (in_ready) begin e.r = m_exp(t[acc], v[acc], b[acc]); e.t = t[acc]; e.v = v[acc]; exp_q.push_back(e); acc++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out();
    total++;
    if (got_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d, required 4", got_q.size()); end
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL bp_order: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] t;
    logic [31:0] v, b;
    int c, sum;
    res_t g;
    exp_t e;
    out_ready = 1'b1;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      rand_req(1'b1, t, v, b);
      send(t, v, b, c);
      sum += c;
    end
    total++;
    if (sum != 16) begin bad++; $display("FAIL throughput: got %0d cycles, required 16", sum); end
    wait_out();
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL b2b_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
  endtask

  task automatic test_random();
    logic [2:0] t;
    logic [31:0] v, b;
    int c;
    res_t g;
    exp_t e;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rand_req(1'b0, t, v, b);
      send(t, v, b, c);
    end
    rnd_rdy = 1'b0;
    wait_out();
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL rand_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
      if (g.err == 2'd0) begin
        total++;
        if (decode(g.instr, e.t) !== e.v) begin
          bad++;
          $display("FAIL round_trip: type %0d decoded %h, required %h", e.t, decode(g.instr, e.t), e.v);
        end
      end
    end
    total++;
    if (err_count !== 8'(n_err > 255 ? 255 : n_err) || err_count2 !== 2'(n_err > 3 ? 3 : n_err)) begin
      bad++;
      $display("FAIL rand_err_count: got %0d/%0d, required %0d/%0d", err_count, err_count2, n_err > 255 ? 255 : n_err, n_err > 3 ? 3 : n_err);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0001, 32'h0000_0013, c);
    send(3'd6, 32'h0000_0000, 32'h0000_0033, c);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: got v=%0b rdy=%0b, required 1 0", out_valid, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || err_count2 !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%0b c=%0d/%0d, required 0 0/0", out_valid, err_count, err_count2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    exp_q.delete();
    n_err = 0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_stale: got %0d results v=%0b, required 0 0", got_q.size(), out_valid);
    end
    got_q.delete();
  endtask

  task automatic test_saturation();
    int c;
    res_t g;
    exp_t e;
    for (int i = 0; i < 5; i++) send(3'(5 + i % 3), $urandom, $urandom, c);
    wait_out();
    while (got_q.size() && exp_q.size()) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); total++;
      if (e.r.err != 2'd0) n_err++;
      if (g !== e.r) begin bad++; $display("FAIL sat_model: got %h/%0d, required %h/%0d", g.instr, g.err, e.r.instr, e.r.err); end
    end
    total++;
    if (err_count !== 8'd5 || err_count2 !== 2'd3) begin
      bad++;
      $display("FAIL saturation: got %0d/%0d, required 5/3", err_count, err_count2);
    end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_type();
    test_range_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decoder: packs a 32-bit immediate value into the RISC-V I/S/B/J/U instruction bit positions of a supplied base instruction.
- Checks range and alignment, then emits the finished instruction.
- Sits between the debug/boot-loader instruction generator and the instruction memory write port.
- Two-stage valid/ready pipeline with backpressure and a saturating error counter.

Parameters:
- CNT_W, 8, width of the saturating error counter err_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder can accept the request this cycle.
- immsrc  input  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 illegal.
- imm  input  32  immediate value as the decoder would produce it (byte offset for B/J; full upper value for U).
- base_instr  input  32  instruction supplying the non-immediate fields; its immediate positions are ignored.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_instr  output  32  encoded instruction.
- out_err  output  2  00 ok, 01 range, 10 misaligned, 11 illegal immsrc.
- err_count  output  CNT_W  saturating count of results accepted with out_err != 00.

Behaviour:
- Reset, asynchronous: both stage valids = 0, out_valid = 0, out_instr = 0, out_err = 00, err_count = 0. Reset mid-transfer drops all in-flight requests.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_instr and out_err are held stable while out_valid & !out_ready.
- Pipeline:
  - S1 registers the packed instruction and the error code.
  - S2 is the output register.
  - Latency: accept at edge N → out_valid high after edge N+1, two cycles later at earliest.
  - Full throughput: one transfer per cycle when out_ready stays high.
- Stall and ready rules:
  - S2 loads from S1 when S2 is empty or S2 transfers.
  - S1 loads from the input when S1 is empty or S1 moves to S2.
  - in_ready = !s1_valid | s1_advance, combinational from out_ready. No bubbles under continuous flow.
  - When both stages are full and out_ready is low, in_ready = 0 and nothing changes.
- Packing: out_instr = base_instr with immediate positions replaced.
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - B: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12].
  - U: [31:12] = imm[31:12].
- Error checks, priority illegal > misaligned > range:
  - Illegal: immsrc in 101-111.
  - Misaligned: B/J with imm[0] = 1.
  - Range:
    - I/S: imm[31:11] not all equal.
    - B: imm[31:12] not all equal.
    - J: imm[31:20] not all equal.
    - U: imm[11:0] != 0. This is reported as range, not misaligned.
  - On any error, out_instr = base_instr with the type's immediate positions cleared to 0. For illegal type: out_instr = base_instr.
- err_count: increments on each output transfer with out_err != 00 and saturates at 2^CNT_W-1, with no wrap.
- Round-trip invariant: for out_err = 00, sign_extend(out_instr[31:7], immsrc) == imm.

Decomposition:
- Shared package holds:
  - immsrc encodings IMM_I/S/B/J/U (3-bit).
  - Error codes ERR_OK/RANGE/ALIGN/ILLEGAL (2-bit).
  - Per-type immediate bit masks.
- Sub-module imm_pack: purely combinational packing and error check, (immsrc, imm, base_instr) → (instr, err).
- imm_encoder holds only the pipeline, handshake and counter.

Test Plan:
- I-type: immsrc=000, imm=0xFFFFF800 (-2048), base=0x00000013 → out_instr=0x80000013, out_err=00, out_valid two cycles after accept.
- B-type: immsrc=010, imm=0xFFFFFFFE (-2), base=0x00000063 → out_instr=0xFE000FE3, err 00. Same with imm=0x3 → err 10, out_instr=0x00000063, err_count=1.
- Range and illegal: J imm=0x00100000 → err 01. U imm=0x00001001 → err 01. immsrc=110 → err 11, out_instr=base. err_count increments per accepted result.
- Backpressure: stream 4 requests with out_ready low → in_ready falls after 2 accepts and outputs stay stable. Raise out_ready → all 4 emerge in order with no loss or duplication. Continuous flow runs at 1/cycle.
- Reset mid-operation: assert reset with both stages full → out_valid=0 and err_count=0 immediately (asynchronous). No stale output after release.
- Saturation and round-trip: CNT_W=2 with 5 error results → err_count=3. Random legal (type, imm) pairs decoded through sign_extend reproduce imm.
